// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed seven-segment bus: rebuilds CNT1..CNT4 from SEL_IN/CNT_IN.
// Optional macro SEG_BCD_CHECK_EN rejects captured values above 9 with an ERR pulse.
module seg_scan_capture #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned CONFIRM = 2,
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] SEL_IN,
    input  logic [3:0] CNT_IN,
    output logic [3:0] CNT1,
    output logic [3:0] CNT2,
    output logic [3:0] CNT3,
    output logic [3:0] CNT4,
    output logic       FRAME_DONE,
    output logic       ERR,
    output logic       STALL
);
    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned CW = $clog2(CONFIRM + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {WAIT_SYNC, SETTLING, CAPTURE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [3:0]      sel_s1, sel, sel_q, cnt_s1, cnt_v;
    logic [1:0]      idx, idx_nxt;
    logic [SW-1:0]   settle_cnt, settle_nxt;
    logic            blank_seen, blank_nxt;
    logic [3:0]      mask, mask_nxt, mask_cap;
    logic [3:0]      cand [4];
    logic [CW-1:0]   conf [4];
    logic [CW-1:0]   conf_cur, conf_new;
    logic            upd_pend;
    logic [1:0]      upd_idx;
    logic [3:0]      cnt_q [4];
    logic [TW-1:0]   stall_cnt, stall_nxt;
    logic            legal_c, cap_c, err_c, done_c, start_c;
    logic            multi_c, sel_chg_c, bcd_bad_c;
    logic [3:0]      cur_c, nxt_c;

    assign cur_c     = 4'b0001 << idx;
    assign nxt_c     = 4'b0001 << (idx + 2'd1);
    assign multi_c   = (sel & (sel - 4'd1)) != 4'b0000;
    assign sel_chg_c = sel != sel_q;
    assign conf_cur  = conf[idx];
    assign conf_new  = (cnt_v == cand[idx])
                     ? ((conf_cur >= CW'(CONFIRM)) ? CW'(CONFIRM) : conf_cur + CW'(1))
                     : CW'(1);

`ifdef SEG_BCD_CHECK_EN
    assign bcd_bad_c = cnt_v > 4'd9;
`else
    assign bcd_bad_c = 1'b0;
`endif

    assign CNT1 = cnt_q[0];
    assign CNT2 = cnt_q[1];
    assign CNT3 = cnt_q[2];
    assign CNT4 = cnt_q[3];

    // Scan-order tracking, capture decisions and frame bookkeeping.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        settle_nxt = settle_cnt;
        blank_nxt  = blank_seen | (sel == 4'b0000);
        mask_nxt   = mask;
        mask_cap   = mask | (bcd_bad_c ? 4'b0000 : cur_c);
        legal_c    = 1'b0;
        cap_c      = 1'b0;
        err_c      = 1'b0;
        done_c     = 1'b0;
        start_c    = 1'b0;
        if (multi_c) begin
            err_c     = sel_chg_c;
            mask_nxt  = 4'b0000;
            state_nxt = WAIT_SYNC;
        end else begin
            case (state)
                WAIT_SYNC: begin
                    if (sel == 4'b0001 && sel_q != 4'b0001) begin
                        idx_nxt = 2'd0;
                        start_c = 1'b1;
                    end
                end
                SETTLING: begin
                    if (sel == cur_c) begin
                        if (settle_cnt + SW'(1) >= SW'(SETTLE)) state_nxt = CAPTURE;
                        else settle_nxt = settle_cnt + SW'(1);
                    end else if (sel == nxt_c) begin
                        idx_nxt = idx + 2'd1;
                        start_c = 1'b1;
                    end else if (sel != 4'b0000) begin
                        err_c     = 1'b1;
                        mask_nxt  = 4'b0000;
                        state_nxt = WAIT_SYNC;
                    end
                end
                CAPTURE: begin
                    cap_c     = 1'b1;
                    err_c     = bcd_bad_c;
                    blank_nxt = sel == 4'b0000;
                    state_nxt = HOLD;
                    // Digit 4 closes the frame; the wrap to digit 1 always starts a fresh mask.
                    if (idx == 2'd3) begin
                        done_c   = (mask_cap == 4'b1111) && !bcd_bad_c;
                        mask_nxt = 4'b0000;
                    end else begin
                        mask_nxt = mask_cap;
                    end
                end
                HOLD: begin
                    if (sel != 4'b0000 && (sel != cur_c || blank_seen)) begin
                        if (sel == nxt_c) begin
                            idx_nxt = idx + 2'd1;
                            start_c = 1'b1;
                        end else if (sel == cur_c) begin
                            start_c = 1'b1;
                        end else begin
                            err_c     = 1'b1;
                            mask_nxt  = 4'b0000;
                            state_nxt = WAIT_SYNC;
                        end
                    end
                end
                default: state_nxt = WAIT_SYNC;
            endcase
        end
        // The cycle that accepts a new digit already counts as the first stable cycle.
        if (start_c) begin
            legal_c    = 1'b1;
            blank_nxt  = 1'b0;
            settle_nxt = SW'(1);
            state_nxt  = (SETTLE <= 1) ? CAPTURE : SETTLING;
        end
        stall_nxt = legal_c ? '0
                  : (stall_cnt == TW'(TIMEOUT)) ? stall_cnt : stall_cnt + TW'(1);
    end

    // Synchronisers and control state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_s1     <= 4'b0000;
            sel        <= 4'b0000;
            sel_q      <= 4'b0000;
            cnt_s1     <= 4'b0000;
            cnt_v      <= 4'b0000;
            state      <= WAIT_SYNC;
            idx        <= 2'd0;
            settle_cnt <= '0;
            blank_seen <= 1'b0;
            mask       <= 4'b0000;
            stall_cnt  <= '0;
            FRAME_DONE <= 1'b0;
            ERR        <= 1'b0;
            STALL      <= 1'b0;
        end else begin
            sel_s1     <= SEL_IN;
            sel        <= sel_s1;
            sel_q      <= sel;
            cnt_s1     <= CNT_IN;
            cnt_v      <= cnt_s1;
            state      <= state_nxt;
            idx        <= idx_nxt;
            settle_cnt <= settle_nxt;
            blank_seen <= blank_nxt;
            mask       <= mask_nxt;
            stall_cnt  <= stall_nxt;
            FRAME_DONE <= done_c && !err_c;
            ERR        <= err_c;
            STALL      <= stall_nxt == TW'(TIMEOUT);
        end
    end

    // Candidate/confirm storage and the registered digit outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                cand[i]  <= 4'b0000;
                conf[i]  <= '0;
                cnt_q[i] <= 4'b0000;
            end
            upd_pend <= 1'b0;
            upd_idx  <= 2'd0;
        end else begin
            upd_pend <= cap_c && !bcd_bad_c && (conf_new == CW'(CONFIRM));
            upd_idx  <= idx;
            if (cap_c && !bcd_bad_c) begin
                cand[idx] <= cnt_v;
                conf[idx] <= conf_new;
            end
            if (upd_pend) cnt_q[upd_idx] <= cand[upd_idx];
        end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with a per-digit-slot model and a per-cycle compare process.
module tb_seg_scan_capture;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned CONFIRM = 2;
    localparam int unsigned TIMEOUT = 1000;
    localparam int MAXC = 4096;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] SEL_IN = 4'b0000;
    logic [3:0] CNT_IN = 4'b0000;
    logic [3:0] CNT1, CNT2, CNT3, CNT4;
    logic       FRAME_DONE, ERR, STALL;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_seen = 0;
    int fd_seen = 0;
    bit chk_en = 1'b0;

    // Expected-output timeline, indexed by clock edge number.
    bit         exp_err  [MAXC];
    bit         exp_fd   [MAXC];
    bit         legal_at [MAXC];
    logic [3:0] upd_mask [MAXC];
    logic [15:0] upd_data [MAXC];
    logic [3:0] e_cnt [4];
    int         stall_ref = 0;

    // Slot-level view of the scan protocol.
    bit         m_sync, m_blank;
    int         m_idx;
    logic [3:0] m_mask, m_prev;
    logic [3:0] m_cand [4];
    int         m_conf [4];

    seg_scan_capture #(.SETTLE(SETTLE), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N), .SEL_IN(SEL_IN), .CNT_IN(CNT_IN),
        .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3), .CNT4(CNT4),
        .FRAME_DONE(FRAME_DONE), .ERR(ERR), .STALL(STALL)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en && RST_N) begin
            if (cyc < MAXC) begin
                if (legal_at[cyc]) stall_ref = cyc;
                for (int d = 0; d < 4; d++)
                    if (upd_mask[cyc][d]) e_cnt[d] = upd_data[cyc][4*d +: 4];
            end
            check("cnt1", CNT1, e_cnt[0]);
            check("cnt2", CNT2, e_cnt[1]);
            check("cnt3", CNT3, e_cnt[2]);
            check("cnt4", CNT4, e_cnt[3]);
            check("err", ERR, (cyc < MAXC) ? int'(exp_err[cyc]) : 0);
            check("frame_done", FRAME_DONE, (cyc < MAXC) ? int'(exp_fd[cyc]) : 0);
            check("stall", STALL, ((cyc - stall_ref) >= int'(TIMEOUT)) ? 1 : 0);
            if (ERR) err_seen++;
            if (FRAME_DONE) fd_seen++;
        end
    end

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic model_capture(input logic [3:0] v, input int t);
        int i;
        i = m_idx;
`ifdef SEG_BCD_CHECK_EN
        if (v > 4'd9) begin
            if (t + 3 + SETTLE < MAXC) exp_err[t + 3 + SETTLE] = 1'b1;
            if (i == 3) m_mask = 4'b0000;
            return;
        end
`endif
        if (v == m_cand[i]) begin
            if (m_conf[i] < int'(CONFIRM)) m_conf[i]++;
        end else begin
            m_cand[i] = v;
            m_conf[i] = 1;
        end
        if (m_conf[i] == int'(CONFIRM) && t + 4 + SETTLE < MAXC) begin
            upd_mask[t + 4 + SETTLE][i] = 1'b1;
            upd_data[t + 4 + SETTLE][4*i +: 4] = m_cand[i];
        end
        m_mask = m_mask | onehot(i);
        if (i == 3) begin
            if (m_mask == 4'b1111 && t + 3 + SETTLE < MAXC) exp_fd[t + 3 + SETTLE] = 1'b1;
            m_mask = 4'b0000;
        end
    endtask

    task automatic model_event(input logic [3:0] s, input logic [3:0] v, input int t);
        int nxt;
        if (s == 4'b0000) begin
            m_blank = 1'b1;
        end else if ($countones(s) > 1) begin
            if (s != m_prev && t + 3 < MAXC) exp_err[t + 3] = 1'b1;
            m_sync = 1'b0;
            m_mask = 4'b0000;
        end else if (!m_sync) begin
            if (s == 4'b0001 && m_prev != 4'b0001) begin
                m_sync = 1'b1;
                m_idx = 0;
                legal_at[t + 3] = 1'b1;
                model_capture(v, t);
            end
        end else begin
            nxt = (m_idx + 1) % 4;
            if (s == onehot(nxt)) begin
                m_idx = nxt;
                legal_at[t + 3] = 1'b1;
                model_capture(v, t);
            end else if (s == onehot(m_idx) && m_blank) begin
                legal_at[t + 3] = 1'b1;
                model_capture(v, t);
            end else begin
                if (t + 3 < MAXC) exp_err[t + 3] = 1'b1;
                m_sync = 1'b0;
                m_mask = 4'b0000;
            end
        end
        if (s != 4'b0000) m_blank = 1'b0;
        m_prev = s;
    endtask

    task automatic slot(input logic [3:0] s, input logic [3:0] v, input int len);
        SEL_IN = s;
        CNT_IN = v;
        model_event(s, v, cyc);
        repeat (len) @(posedge CLK);
        #1;
    endtask

    task automatic scan(input logic [3:0] v1, input logic [3:0] v2,
                        input logic [3:0] v3, input logic [3:0] v4);
        slot(4'b0001, v1, 20);
        slot(4'b0010, v2, 20);
        slot(4'b0100, v3, 20);
        slot(4'b1000, v4, 20);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST_N  = 1'b0;
        chk_en = 1'b0;
        #1;
        check("rst_cnt", int'({CNT4, CNT3, CNT2, CNT1}), 0);
        check("rst_flags", int'({FRAME_DONE, ERR, STALL}), 0);
        for (int i = 0; i < MAXC; i++) begin
            exp_err[i] = 1'b0; exp_fd[i] = 1'b0; legal_at[i] = 1'b0;
            upd_mask[i] = 4'b0000; upd_data[i] = 16'h0000;
        end
        for (int d = 0; d < 4; d++) begin
            e_cnt[d] = 4'b0000; m_cand[d] = 4'b0000; m_conf[d] = 0;
        end
        m_sync = 1'b0; m_blank = 1'b0; m_idx = 0; m_mask = 4'b0000; m_prev = 4'b0000;
        repeat (3) @(posedge CLK);
        #1;
        RST_N     = 1'b1;
        stall_ref = cyc;
        chk_en    = 1'b1;
    endtask

    initial begin
        int e0, f0;
        do_reset();

        // Digit 3 never confirms when its value alternates.
        for (int f = 0; f < 3; f++) scan(4'd1, 4'd2, (f % 2) ? 4'd5 : 4'd3, 4'd4);
        check("alt_cnt3", CNT3, 0);
        check("alt_cnt1", CNT1, 1);

        do_reset();
        f0 = fd_seen;
        scan(4'd1, 4'd2, 4'd3, 4'd4);
        check("pass1_cnt1", CNT1, 0);
        scan(4'd1, 4'd2, 4'd3, 4'd4);
        check("pass2_cnts", int'({CNT4, CNT3, CNT2, CNT1}), 16'h4321);
        // Blank then the same digit re-captures without closing a frame.
        slot(4'b0000, 4'd0, 20);
        slot(4'b1000, 4'd4, 20);
        check("two_frames", fd_seen - f0, 2);

        // Reset after digit 2, then re-enter mid-scan.
        slot(4'b0001, 4'd7, 20);
        slot(4'b0010, 4'd8, 20);
        do_reset();
        f0 = fd_seen;
        slot(4'b0100, 4'd3, 20);
        slot(4'b1000, 4'd4, 20);
        check("midscan_no_frame", fd_seen - f0, 0);
        scan(4'd1, 4'd2, 4'd3, 4'd4);
        scan(4'd1, 4'd2, 4'd3, 4'd4);
        check("restore_cnts", int'({CNT4, CNT3, CNT2, CNT1}), 16'h4321);

        // Out-of-order select, then a multi-bit select.
        e0 = err_seen;
        f0 = fd_seen;
        slot(4'b0001, 4'd1, 20);
        slot(4'b0100, 4'd3, 20);
        slot(4'b0011, 4'd0, 20);
        check("order_errs", err_seen - e0, 2);
        check("order_no_frame", fd_seen - f0, 0);

        // Stuck select raises STALL; the next legal change drops it.
        slot(4'b0001, 4'd1, 20);
        slot(4'b0010, 4'd2, 1010);
        check("stall_set", STALL, 1);
        repeat (190) @(posedge CLK);
        #1;
        slot(4'b0100, 4'd3, 20);
        check("stall_clear", STALL, 0);

`ifdef SEG_BCD_CHECK_EN
        e0 = err_seen;
        f0 = fd_seen;
        slot(4'b1000, 4'd4, 20);
        scan(4'd1, 4'd12, 4'd3, 4'd4);
        scan(4'd1, 4'd12, 4'd3, 4'd4);
        check("bcd_errs", err_seen - e0, 2);
        check("bcd_no_frame", fd_seen - f0, 0);
        check("bcd_cnt2", CNT2, 2);
`endif

        repeat (10) @(posedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
